input_debouncer: RTL and testbench

- Upstream conditioning stage for the memory-mapped input devices (keys, switches).
- Synchronizes asynchronous board inputs into the clk domain, optionally inverts active-low inputs, and debounces each bit with a shared sample-tick prescaler.
- Its `device` output drives the `device` input of the mapped input register. Only genuine, stable transitions produce a data change there, so ready/overrun are not triggered by contact bounce.
- Also emits per-bit rise/fall pulses and an aggregate `changed` pulse for future edge-triggered consumers.

---
 rtl/input_debouncer_pkg.sv | 23 ++
 rtl/input_debouncer_debounce_bit.sv | 54 +++++
 rtl/input_debouncer.sv | 65 ++++++
 tb/tb_input_debouncer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared constants and sizing helpers for the input debouncer and its per-bit slices.
package input_debouncer_pkg;

    // Clocks per millisecond at the 50 MHz board clock.
    localparam int TICK_1MS = 50000;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    function automatic int min1_width(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

endpackage

// File: rtl/input_debouncer_debounce_bit.sv
// One input bit: two-flop synchronizer, tick-qualified stability counter, accepted level and edge pulses.
module debounce_bit
    import input_debouncer_pkg::*;
#(
    parameter int   STABLE_TICKS = 8,
    parameter logic RESET_VALUE  = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample,
    input  logic tick,
    output logic device,
    output logic rise,
    output logic fall,
    output logic accept
);

    localparam int              CNT_W    = min1_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    // Equality with the accepted level always wins, so a returning glitch on the final tick is ignored.
    assign accept = tick && (sync2 != device) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= RESET_VALUE;
            sync2  <= RESET_VALUE;
            device <= RESET_VALUE;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync1 <= sample;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            if (sync2 == device) begin
                cnt <= '0;
            end else if (accept) begin
                device <= sync2;
                cnt    <= '0;
                rise   <= sync2;
                fall   <= ~sync2;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Conditions asynchronous keys/switches: optional inversion, synchronization and tick-based debounce.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int               WIDTH        = 4,
    parameter int               TICK_DIV     = TICK_1MS,
    parameter int               STABLE_TICKS = 8,
    parameter logic [WIDTH-1:0] INVERT       = '0,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] device,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             tick
);

    localparam int              DIV_W    = min1_width(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] accept;

    assign sample = raw ^ INVERT;

    // Shared prescaler: tick is registered, so it is high in the clock after div_cnt reaches DIV_LAST.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            tick    <= (div_cnt == DIV_LAST);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS),
            .RESET_VALUE (RESET_VALUE[i])
        ) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .sample (sample[i]),
            .tick   (tick),
            .device (device[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .accept (accept[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            changed <= 1'b0;
        end else begin
            changed <= |accept;
        end
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with TICK_DIV=4, STABLE_TICKS=3 and an inverted-bit instance.
module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] raw = 4'hF;
    logic [3:0] raw2 = 4'h0;
    logic [3:0] device, rise, fall;
    logic [3:0] device2, rise2, fall2;
    logic       changed, tick, changed2, tick2;

    int total = 0;
    int passed = 0;
    int failed = 0;

    always #5 clk = ~clk;

    input_debouncer #(
        .WIDTH(4), .TICK_DIV(4), .STABLE_TICKS(3), .INVERT(4'b0000), .RESET_VALUE(4'b0000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw(raw), .device(device),
        .rise(rise), .fall(fall), .changed(changed), .tick(tick)
    );

    input_debouncer #(
        .WIDTH(4), .TICK_DIV(4), .STABLE_TICKS(3), .INVERT(4'b1000), .RESET_VALUE(4'b1000)
    ) dut_inv (
        .clk(clk), .reset_n(reset_n), .raw(raw2), .device(device2),
        .rise(rise2), .fall(fall2), .changed(changed2), .tick(tick2)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic wait_bit(input int idx, input logic target, output int n);
        n = 0;
        while (device[idx] !== target && n < 40) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        int rise_cnt;
        int bad;

        // Reset held with all inputs high
        repeat (3) cyc();
        check("rst_device", device, 4'h0);
        check("rst_rise", rise, 4'h0);
        check("rst_fall", fall, 4'h0);
        check("rst_changed", changed, 1'b0);
        check("rst_tick", tick, 1'b0);
        check("rst_device_inv", device2, 4'b1000);

        raw = 4'h0;
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            check($sformatf("tick_phase_%0d", k), tick, (k % 4 == 0) ? 1'b1 : 1'b0);
        end

        // Clean press on bit 0
        raw[0] = 1'b1;
        wait_bit(0, 1'b1, n);
        check("press_latency", (n >= 11 && n <= 14) ? 1 : 0, 1);
        check("press_rise", rise, 4'b0001);
        check("press_changed", changed, 1'b1);
        check("press_fall", fall, 4'b0000);
        cyc();
        check("press_rise_end", rise, 4'b0000);
        check("press_changed_end", changed, 1'b0);
        check("press_device", device, 4'b0001);

        // Bounce on bit 1, then settle high
        rise_cnt = 0;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            raw[1] = ((i / 3) % 2 == 0);
            cyc();
            if (device[1] !== 1'b0) bad++;
            if (rise[1] === 1'b1) rise_cnt++;
        end
        check("bounce_hold", bad, 0);
        raw[1] = 1'b1;
        n = 0;
        while (device[1] !== 1'b1 && n < 40) begin
            cyc();
            n++;
            if (rise[1] === 1'b1) rise_cnt++;
        end
        check("bounce_latency", (n >= 11 && n <= 14) ? 1 : 0, 1);
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (rise[1] === 1'b1) rise_cnt++;
        end
        check("bounce_rise_count", rise_cnt, 1);
        check("bounce_device", device, 4'b0011);

        // Six-clock glitch on bit 2
        bad = 0;
        raw[2] = 1'b1;
        for (int i = 0; i < 36; i++) begin
            if (i == 6) raw[2] = 1'b0;
            cyc();
            if (device[2] !== 1'b0 || rise !== 4'h0 || fall !== 4'h0 || changed !== 1'b0) bad++;
        end
        check("glitch_ignored", bad, 0);
        check("glitch_device", device, 4'b0011);

        // Simultaneous update with an inverted bit
        raw2 = 4'b1011;
        n = 0;
        while (device2 === 4'b1000 && n < 40) begin
            cyc();
            n++;
        end
        check("inv_latency", (n >= 11 && n <= 14) ? 1 : 0, 1);
        check("inv_device", device2, 4'b0011);
        check("inv_rise", rise2, 4'b0011);
        check("inv_fall", fall2, 4'b1000);
        check("inv_changed", changed2, 1'b1);
        cyc();
        check("inv_changed_end", changed2, 1'b0);
        check("inv_edges_end", {rise2, fall2}, 8'h00);

        // Release bit 0
        raw[0] = 1'b0;
        wait_bit(0, 1'b0, n);
        check("release_latency", (n >= 11 && n <= 14) ? 1 : 0, 1);
        check("release_fall", fall, 4'b0001);
        check("release_rise", rise, 4'b0000);
        cyc();

        // Reset in the middle of a debounce
        raw[0] = 1'b1;
        repeat (5) cyc();
        reset_n = 1'b0;
        #2;
        check("midrst_device", device, 4'h0);
        check("midrst_tick", tick, 1'b0);
        check("midrst_edges", {changed, rise, fall}, 9'h000);
        check("midrst_device_inv", device2, 4'b1000);
        repeat (3) cyc();
        check("midrst_hold", device, 4'h0);
        reset_n = 1'b1;
        n = 0;
        while (device === 4'h0 && n < 40) begin
            cyc();
            n++;
        end
        check("midrst_latency", n, 13);
        check("midrst_device_after", device, 4'b0011);
        check("midrst_rise", rise, 4'b0011);
        check("midrst_changed", changed, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
